addsub_slice_seq: RTL

//  Parametrised, multi-cycle add/subtract unit for the ALU datapath. Processes WIDTH-bit

---
 rtl/alu_pkg.sv | 15 +
 rtl/slice_adder.sv | 19 +
 rtl/addsub_slice_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding, operation encoding and slice-count helper.
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  function automatic int num_slices(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational SLICE-bit adder; also reports the carry into its top bit for signed overflow.
module slice_adder #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_into_msb
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    // Recover the carry into the top bit from its sum: s = a ^ b ^ c.
    c_into_msb  = a[SLICE-1] ^ b[SLICE-1] ^ sum[SLICE-1];
  end

endmodule

// File: rtl/addsub_slice_seq.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed SLICE bits per cycle, LSB slice first.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; in_ready is 1
// only in IDLE, out_valid is 1 only in DONE and holds result and flags until out_ready is seen.
module addsub_slice_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ctrl,
  input  logic             Sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             Z,
  output logic             V,
  output logic             N,
  output logic             C,
  output logic [1:0]       state_dbg
);

  localparam int NS = num_slices(WIDTH, SLICE);
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] bx_sh;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_next;
  logic             carry_r;
  logic             ctrl_r;
  logic             sign_r;

  logic [SLICE-1:0] sum;
  logic             cout;
  logic             c_into_msb;
  logic             last;
  logic             v_s;
  logic             v_u;

  // Operands shift right each slice so the adder always sees bits [SLICE-1:0].
  slice_adder #(.SLICE(SLICE)) u_slice_adder (
    .a          (a_sh[SLICE-1:0]),
    .b          (bx_sh[SLICE-1:0]),
    .cin        (carry_r),
    .sum        (sum),
    .cout       (cout),
    .c_into_msb (c_into_msb)
  );

  always_comb begin
    res_next = res_r >> SLICE;
    res_next[WIDTH-1 -: SLICE] = sum;
    last = (idx == IW'(NS - 1));
    v_s  = c_into_msb ^ cout;
    v_u  = ctrl_r ? ~cout : cout;
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      a_sh    <= '0;
      bx_sh   <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      ctrl_r  <= 1'b0;
      sign_r  <= 1'b0;
      dout    <= '0;
      Z       <= 1'b0;
      V       <= 1'b0;
      N       <= 1'b0;
      C       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh    <= A;
            // Subtraction is A + ~B + 1; the +1 enters as the first carry-in.
            bx_sh   <= (ctrl == ALU_SUB) ? ~B : B;
            carry_r <= ctrl;
            ctrl_r  <= ctrl;
            sign_r  <= Sign;
            idx     <= '0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          a_sh    <= a_sh >> SLICE;
          bx_sh   <= bx_sh >> SLICE;
          carry_r <= cout;
          res_r   <= res_next;
          idx     <= idx + 1'b1;
          if (last) begin
            state <= ST_DONE;
            dout  <= res_next;
            Z     <= ~|res_next;
            C     <= cout;
            V     <= sign_r ? v_s : v_u;
            N     <= sign_r ? (res_next[WIDTH-1] ^ v_s) : (ctrl_r & ~cout);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
